// File: rtl/wf68k30l_movem_seq_if.sv
// MOVEM sequencer bus bundle: command/mode inputs, bus handshake and register-file strobes.
// master = controller side (drives start/mode/ack), slave = sequencer side (drives req/strobes/status).
// No storage here; timing is owned entirely by the sequencer.
interface wf68k30l_movem_seq_if;
  logic        start;
  logic [15:0] reg_mask;
  logic        predec;
  logic        dir_to_mem;
  logic        size_long;
  logic        abort;
  logic        reg_in_use;
  logic        xfer_ack;
  logic        xfer_req;
  logic [2:0]  reg_sel;
  logic        reg_is_adr;
  logic        dr_wr;
  logic        ar_wr;
  logic        sext;
  logic [4:0]  xfer_cnt;
  logic        busy;
  logic        done;

  modport master (
    output start, reg_mask, predec, dir_to_mem, size_long, abort, reg_in_use, xfer_ack,
    input  xfer_req, reg_sel, reg_is_adr, dr_wr, ar_wr, sext, xfer_cnt, busy, done
  );

  modport slave (
    input  start, reg_mask, predec, dir_to_mem, size_long, abort, reg_in_use, xfer_ack,
    output xfer_req, reg_sel, reg_is_adr, dr_wr, ar_wr, sext, xfer_cnt, busy, done
  );
endinterface

// File: rtl/wf68k30l_movem_seq.sv
// MOVEM register-list sequencer: walks a 16-bit mask, one bus transfer per register, write-back for mem->reg.
// Latency: START -> first XFER_REQ next cycle; to-mem next req 1 cycle after ACK, from-mem 2 cycles (WB slot).
// Backpressure: XFER_REQ held until XFER_ACK; withheld while REG_IN_USE on register-to-memory; ABORT cancels.
// Ports: clk, rst (async, active-high); bus = slave side of wf68k30l_movem_seq_if.
module wf68k30l_movem_seq (
  input  logic                    clk,
  input  logic                    rst,
  wf68k30l_movem_seq_if.slave     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]  state;
  logic [15:0] pending;
  logic        predec_q;
  logic        to_mem_q;
  logic        long_q;
  logic [3:0]  wb_idx;
  logic [4:0]  cnt;

  logic [3:0]  low_idx;
  logic [15:0] rest;
  logic        in_xfer;
  logic        in_wb;
  logic        req;
  logic        accept;
  logic        strobe;
  logic [3:0]  sel_idx;

  // Lowest set pending bit; descending scan so the lowest index wins.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) low_idx = 4'(i);
    end
  end

  assign rest    = pending & ~(16'd1 << low_idx);
  assign in_xfer = (state == S_XFER);
  assign in_wb   = (state == S_WB);
  assign req     = in_xfer && !(to_mem_q && bus.reg_in_use);
  assign accept  = req && bus.xfer_ack && !bus.abort;
  assign strobe  = in_wb && !bus.abort;

  // In WB the register is the one just transferred; pending no longer holds it.
  assign sel_idx = in_wb ? wb_idx : low_idx;

  // Predecrement list is bit-reversed: bit i -> 7-i / 15-i, which is the inverted low
  // three bits, with the Dn/An split flipped.
  always_comb begin
    bus.reg_sel    = 3'd0;
    bus.reg_is_adr = 1'b0;
    if (in_xfer || in_wb) begin
      bus.reg_sel    = predec_q ? ~sel_idx[2:0] : sel_idx[2:0];
      bus.reg_is_adr = sel_idx[3] ^ predec_q;
    end
  end

  assign bus.xfer_req = req;
  assign bus.dr_wr    = strobe && !bus.reg_is_adr;
  assign bus.ar_wr    = strobe && bus.reg_is_adr;
  assign bus.sext     = strobe && !long_q;
  assign bus.xfer_cnt = cnt;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_FIN) && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pending  <= 16'd0;
      predec_q <= 1'b0;
      to_mem_q <= 1'b0;
      long_q   <= 1'b0;
      wb_idx   <= 4'd0;
      cnt      <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pending  <= bus.reg_mask;
            predec_q <= bus.predec;
            to_mem_q <= bus.dir_to_mem;
            long_q   <= bus.size_long;
            cnt      <= 5'd0;
            state    <= (bus.reg_mask == 16'd0) ? S_FIN : S_XFER;
          end
        end
        S_XFER: begin
          if (bus.abort) begin
            state   <= S_IDLE;
            pending <= 16'd0;
          end else if (accept) begin
            pending <= rest;
            cnt     <= cnt + 5'd1;
            wb_idx  <= low_idx;
            if (to_mem_q) state <= (rest != 16'd0) ? S_XFER : S_FIN;
            else          state <= S_WB;
          end
        end
        S_WB: begin
          if (bus.abort) begin
            state   <= S_IDLE;
            pending <= 16'd0;
          end else begin
            state <= (pending != 16'd0) ? S_XFER : S_FIN;
          end
        end
        S_FIN: begin
          state   <= S_IDLE;
          pending <= 16'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wf68k30l_movem_seq.md
WF68K30L_MOVEM_SEQ -- requirements
Module: WF68K30L_MOVEM_SEQ

Interface
REQ-001 CLK  in  1  sole clock; all state changes on rising edge.
REQ-002 RESET  in  1  asynchronous, active-high reset.
REQ-003 START  in  1  begin a MOVEM sequence; sampled only in IDLE.
REQ-004 REG_MASK  in  16  register list; sampled with START.
REQ-005 PREDEC  in  1  1 = predecrement list format; sampled with START.
REQ-006 DIR_TO_MEM  in  1  1 = register-to-memory, 0 = memory-to-register; sampled with START.
REQ-007 SIZE_LONG  in  1  1 = long, 0 = word transfers; sampled with START.
REQ-008 ABORT  in  1  synchronous cancel (bus error/exception).
REQ-009 REG_IN_USE  in  1  scoreboard hit for current register (from data/address register in-use logic).
REQ-010 XFER_ACK  in  1  bus transfer for current register complete.
REQ-011 XFER_REQ  out  1  request one bus transfer for current register.
REQ-012 REG_SEL  out  3  current register number, drives DR_SEL_RD/DR_SEL_WR or address-register equivalent.
REQ-013 REG_IS_ADR  out  1  0 = Dn, 1 = An.
REQ-014 DR_WR / AR_WR  out  1 each  one-cycle write strobe to data / address register file.
REQ-015 SEXT  out  1  1 when write data is word and must be sign-extended to 32 bits.
REQ-016 XFER_CNT  out  5  completed transfers in current sequence, 0..16.
REQ-017 BUSY  out  1  high in every state except IDLE.
REQ-018 DONE  out  1  one-cycle completion pulse.

Function
REQ-019 States: IDLE, XFER, WB, FIN; FSM shall hold exactly one state.
REQ-020 Mask mapping: normal, bit i = D[i] for i<8, A[i-8] for i>=8; PREDEC, bit i = A[7-i] for i<8, D[15-i] for i>=8.
REQ-021 Order: lowest set pending mask bit first (normal D0..A7, PREDEC A7..D0).
REQ-022 IDLE + START: latch mask into 16-bit pending register, latch mode bits, clear XFER_CNT; next state XFER, or FIN if REG_MASK = 0.
REQ-023 XFER: REG_SEL/REG_IS_ADR = priority-encoded lowest pending bit; XFER_REQ = 1 unless DIR_TO_MEM=1 and REG_IN_USE=1.
REQ-024 XFER_ACK while XFER_REQ=1: clear that pending bit, XFER_CNT+1; to-mem: stay XFER if bits remain, else FIN; from-mem: go WB.
REQ-025 WB: exactly one cycle; DR_WR (REG_IS_ADR=0) or AR_WR (REG_IS_ADR=1) high, REG_SEL held at the written register; SEXT = not SIZE_LONG; next XFER if bits remain, else FIN.
REQ-026 FIN: DONE=1 for one cycle, then IDLE.
REQ-027 Latency: START at cycle 0 -> XFER_REQ at cycle 1; to-mem next XFER_REQ the cycle after ACK; from-mem next XFER_REQ two cycles after ACK.
REQ-028 XFER_ACK while XFER_REQ=0 or outside XFER shall be ignored.
REQ-029 START while BUSY=1 shall be ignored; mode inputs shall not affect an active sequence.
REQ-030 ABORT in any non-IDLE state: IDLE next cycle, no DONE, no write strobe, pending cleared; ABORT has priority over XFER_ACK in same cycle.
REQ-031 XFER_CNT holds its final value in IDLE until next accepted START; maximum 16 (all bits set).
REQ-032 Outside WB, DR_WR=AR_WR=SEXT=0; outside XFER, XFER_REQ=0.

Reset
REQ-033 RESET=1 forces IDLE immediately; XFER_REQ, DR_WR, AR_WR, SEXT, BUSY, DONE = 0; REG_SEL=0, REG_IS_ADR=0, XFER_CNT=0, pending=0.
REQ-034 RESET mid-sequence shall produce no DONE and no write strobe on release.

Verification
REQ-035 To-mem, normal, mask 16'h8101, ACK every req cycle -> REG_SEL sequence D0, A0, A7 (REG_IS_ADR 0,1,1) on consecutive cycles 1-3, DONE at cycle 4, XFER_CNT=3.
REQ-036 From-mem, PREDEC, mask 16'h8001, SIZE_LONG=0 -> first A7 ACK, WB with AR_WR=1 SEXT=1 REG_SEL=7; then D0 ACK, WB with DR_WR=1 REG_SEL=0; DONE; XFER_CNT=2.
REQ-037 START with mask 16'h0000 -> BUSY cycle 1, DONE at cycle 1, no XFER_REQ, XFER_CNT=0.
REQ-038 To-mem, mask 16'h0004, REG_IN_USE=1 for 3 cycles -> XFER_REQ=0 those cycles, REG_SEL=2, then XFER_REQ=1; ACK -> DONE.
REQ-039 Mask 16'hFFFF from-mem, ABORT asserted with 5th ACK -> IDLE next cycle, no DONE, XFER_CNT=4, no 5th write strobe.
REQ-040 RESET asserted mid-WB -> DR_WR drops asynchronously, all outputs at reset values; new START afterwards runs normally.
